mem_mesh_pipe: RTL and testbench

MEM_MESH_PIPE -- requirements
Module: mem_mesh_pipe

---
 rtl/mem_mesh_pipe_if.sv | 32 +++
 rtl/mem_mesh_pipe.sv | 207 ++++++++++++++++++++
 tb/tb_mem_mesh_pipe.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_mesh_pipe_if.sv
// rtl/mem_mesh_pipe_if.sv - core write/read bus and io port bundle for mem_mesh_pipe
interface mem_mesh_pipe_if #(
    parameter int CORES        = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter int SPREAD_WIDTH = 3,
    parameter int IO_PORTS     = 16
);
    logic [CORES-1:0]                 we;
    logic [CORES*ADDR_WIDTH-1:0]      waddr;
    logic [CORES*SPREAD_WIDTH-1:0]    wspread;
    logic [CORES*DATA_WIDTH-1:0]      wdata;
    logic [CORES*ADDR_WIDTH-1:0]      raddr;
    logic [CORES*DATA_WIDTH-1:0]      rdata;
    logic [CORES-1:0]                 wlost;
    logic [IO_PORTS-1:0]              io_active_in;
    logic [IO_PORTS*DATA_WIDTH-1:0]   io_data_in;
    logic [IO_PORTS-1:0]              io_valid_out;
    logic [IO_PORTS*DATA_WIDTH-1:0]   io_data_out;
    logic [IO_PORTS-1:0]              io_ready_in;
    logic [IO_PORTS-1:0]              io_overrun;

    modport master (
        output we, waddr, wspread, wdata, raddr, io_active_in, io_data_in, io_ready_in,
        input  rdata, wlost, io_valid_out, io_data_out, io_overrun
    );

    modport slave (
        input  we, waddr, wspread, wdata, raddr, io_active_in, io_data_in, io_ready_in,
        output rdata, wlost, io_valid_out, io_data_out, io_overrun
    );
endinterface

// File: rtl/mem_mesh_pipe.sv
// rtl/mem_mesh_pipe.sv - per-core RAM blocks with prioritised spread writes and io-mapped cells
module mem_mesh_pipe #(
    parameter int CORES         = 8,
    parameter int DEPTH         = 256,
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 8,
    parameter int SPREAD_LAYERS = 3,
    parameter int SPREAD_WIDTH  = 3,
    parameter int USE_IO        = 1,
    parameter int IO_PORTS      = 16,
    parameter int IO_FIRST      = 240
) (
    input  logic            clk,
    input  logic            rst,
    mem_mesh_pipe_if.slave  bus
);
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int SW = SPREAD_WIDTH;
    // spread that reaches every block and also feeds the io outputs
    localparam logic [SW-1:0] SPR_MAX = SW'(SPREAD_LAYERS + 1);
    localparam logic          IO_ON   = (USE_IO != 0);

    logic [DW-1:0]       mem      [CORES][DEPTH];

    logic [CORES-1:0]    st_we;
    logic [AW-1:0]       st_waddr [CORES];
    logic [SW-1:0]       st_spr   [CORES];
    logic [DW-1:0]       st_wdata [CORES];
    logic [IO_PORTS-1:0] st_io_act;
    logic [DW-1:0]       st_io_data [IO_PORTS];

    logic [SW-1:0]       spr_clamp [CORES];
    logic [CORES-1:0]    win       [CORES];
    logic [DW-1:0]       rd_next   [CORES];
    logic [IO_PORTS-1:0] bc_hit;
    logic [DW-1:0]       bc_data   [IO_PORTS];

    logic [DW-1:0]       rdata_q   [CORES];
    logic [CORES-1:0]    wlost_q;
    logic [CORES*DW-1:0] rdata_flat;

    // oversized spreads behave exactly like the broadcast spread
    always_comb begin
        for (int c = 0; c < CORES; c++) begin
            spr_clamp[c] = bus.wspread[c*SW +: SW];
            if (spr_clamp[c] > SPR_MAX)
                spr_clamp[c] = SPR_MAX;
        end
    end

    // write stage: capture all write sources one edge ahead of the commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_we     <= '0;
            st_io_act <= '0;
            for (int c = 0; c < CORES; c++) begin
                st_waddr[c] <= '0;
                st_spr[c]   <= '0;
                st_wdata[c] <= '0;
            end
            for (int p = 0; p < IO_PORTS; p++)
                st_io_data[p] <= '0;
        end else begin
            st_we     <= bus.we;
            st_io_act <= bus.io_active_in & {IO_PORTS{IO_ON}};
            for (int c = 0; c < CORES; c++) begin
                st_waddr[c] <= bus.waddr[c*AW +: AW];
                st_spr[c]   <= spr_clamp[c];
                st_wdata[c] <= bus.wdata[c*DW +: DW];
            end
            for (int p = 0; p < IO_PORTS; p++)
                st_io_data[p] <= IO_ON ? bus.io_data_in[p*DW +: DW] : '0;
        end
    end

    // win[b][c]: staged core c owns its address in block b (io input beats all,
    // then larger spread, then lower core index); a block is reached when the
    // block and core index agree above the lowest spread bits
    always_comb begin
        for (int b = 0; b < CORES; b++) begin
            win[b] = '0;
            for (int c = 0; c < CORES; c++) begin
                if (st_we[c] && (((b ^ c) >> st_spr[c]) == 0)) begin
                    win[b][c] = 1'b1;
                    for (int d = 0; d < CORES; d++) begin
                        if (d != c && st_we[d] && (((b ^ d) >> st_spr[d]) == 0) &&
                            st_waddr[d] == st_waddr[c] &&
                            (st_spr[d] > st_spr[c] || (st_spr[d] == st_spr[c] && d < c)))
                            win[b][c] = 1'b0;
                    end
                    for (int p = 0; p < IO_PORTS; p++) begin
                        if (st_io_act[p] && st_waddr[c] == AW'(IO_FIRST + p))
                            win[b][c] = 1'b0;
                    end
                end
            end
        end
    end

    // broadcast to an io cell: lowest-index broadcaster wins unless io input claims the cell
    always_comb begin
        bc_hit = '0;
        for (int p = 0; p < IO_PORTS; p++) begin
            bc_data[p] = '0;
            for (int c = CORES - 1; c >= 0; c--) begin
                if (st_we[c] && st_spr[c] == SPR_MAX && st_waddr[c] == AW'(IO_FIRST + p)
                    && !st_io_act[p]) begin
                    bc_hit[p]  = 1'b1;
                    bc_data[p] = st_wdata[c];
                end
            end
        end
    end

    // read value as it will stand after this edge's commit
    always_comb begin
        for (int c = 0; c < CORES; c++) begin
            rd_next[c] = mem[c][bus.raddr[c*AW +: AW]];
            for (int d = 0; d < CORES; d++) begin
                if (win[c][d] && st_waddr[d] == bus.raddr[c*AW +: AW])
                    rd_next[c] = st_wdata[d];
            end
            for (int p = 0; p < IO_PORTS; p++) begin
                if (st_io_act[p] && AW'(IO_FIRST + p) == bus.raddr[c*AW +: AW])
                    rd_next[c] = st_io_data[p];
            end
        end
    end

    // commit: winners write their blocks, io inputs write their cell in every block
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < CORES; b++)
                for (int a = 0; a < DEPTH; a++)
                    mem[b][a] <= '0;
        end else begin
            for (int b = 0; b < CORES; b++) begin
                for (int c = 0; c < CORES; c++) begin
                    if (win[b][c])
                        mem[b][st_waddr[c]] <= st_wdata[c];
                end
                for (int p = 0; p < IO_PORTS; p++) begin
                    if (st_io_act[p])
                        mem[b][AW'(IO_FIRST + p)] <= st_io_data[p];
                end
            end
        end
    end

    // registered read data and per-core lost-write flag for the core's own block
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wlost_q <= '0;
            for (int c = 0; c < CORES; c++)
                rdata_q[c] <= '0;
        end else begin
            for (int c = 0; c < CORES; c++) begin
                rdata_q[c] <= rd_next[c];
                wlost_q[c] <= st_we[c] && !win[c][c];
            end
        end
    end

    always_comb begin
        rdata_flat = '0;
        for (int c = 0; c < CORES; c++)
            rdata_flat[c*DW +: DW] = rdata_q[c];
    end

    assign bus.rdata = rdata_flat;
    assign bus.wlost = wlost_q;

    if (USE_IO != 0) begin : g_io
        logic [IO_PORTS-1:0]    valid_q;
        logic [IO_PORTS-1:0]    overrun_q;
        logic [IO_PORTS*DW-1:0] data_q;

        // outgoing io words: reload on broadcast, drop on consumer accept, flag overwrites
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q   <= '0;
                overrun_q <= '0;
                data_q    <= '0;
            end else begin
                for (int p = 0; p < IO_PORTS; p++) begin
                    if (bc_hit[p]) begin
                        valid_q[p]          <= 1'b1;
                        data_q[p*DW +: DW]  <= bc_data[p];
                        if (valid_q[p] && !bus.io_ready_in[p])
                            overrun_q[p] <= 1'b1;
                    end else if (valid_q[p] && bus.io_ready_in[p]) begin
                        valid_q[p] <= 1'b0;
                    end
                end
            end
        end

        assign bus.io_valid_out = valid_q;
        assign bus.io_overrun   = overrun_q;
        assign bus.io_data_out  = data_q;
    end else begin : g_no_io
        assign bus.io_valid_out = '0;
        assign bus.io_overrun   = '0;
        assign bus.io_data_out  = '0;
    end
endmodule

// File: tb/tb_mem_mesh_pipe.sv
// tb/tb_mem_mesh_pipe.sv - directed self-checking bench for mem_mesh_pipe
module tb_mem_mesh_pipe;
    localparam int C  = 8;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int SW = 3;
    localparam int IP = 16;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    mem_mesh_pipe_if #(.CORES(C), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                       .SPREAD_WIDTH(SW), .IO_PORTS(IP)) bus ();

    mem_mesh_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_writes();
        bus.we           = '0;
        bus.waddr        = '0;
        bus.wspread      = '0;
        bus.wdata        = '0;
        bus.io_active_in = '0;
        bus.io_data_in   = '0;
    endtask

    task automatic put_write(input int c, input int addr, input int spr, input logic [15:0] d);
        logic [31:0] a32;
        logic [31:0] s32;
        a32 = addr;
        s32 = spr;
        bus.we[c]               = 1'b1;
        bus.waddr[c*AW +: AW]   = a32[AW-1:0];
        bus.wspread[c*SW +: SW] = s32[SW-1:0];
        bus.wdata[c*DW +: DW]   = d;
    endtask

    task automatic read_all(input int addr);
        logic [31:0] a32;
        a32 = addr;
        for (int c = 0; c < C; c++)
            bus.raddr[c*AW +: AW] = a32[AW-1:0];
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        clear_writes();
        bus.raddr       = '0;
        bus.io_ready_in = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        check("reset_rdata", bus.rdata[31:0], 32'h0);
        check("reset_wlost", bus.wlost, 32'h0);
        check("reset_io_valid", bus.io_valid_out, 32'h0);
        check("reset_io_overrun", bus.io_overrun, 32'h0);

        // own-block write, read back one cycle later
        put_write(3, 5, 0, 16'h1234);
        tick();
        clear_writes();
        read_all(5);
        tick();
        check("own_write_core3", bus.rdata[3*DW +: DW], 32'h1234);
        check("own_write_core2", bus.rdata[2*DW +: DW], 32'h0);
        check("own_write_wlost3", bus.wlost[3], 1'b0);

        // spread 1 vs spread 2 on the same address: larger spread wins
        put_write(0, 9, 1, 16'hAAAA);
        put_write(1, 9, 2, 16'hBBBB);
        tick();
        clear_writes();
        read_all(9);
        tick();
        check("spread_wlost0", bus.wlost[0], 1'b1);
        check("spread_wlost1", bus.wlost[1], 1'b0);
        for (int b = 0; b < 4; b++)
            check($sformatf("spread_blk%0d", b), bus.rdata[b*DW +: DW], 32'hBBBB);
        check("spread_blk4", bus.rdata[4*DW +: DW], 32'h0);
        tick();
        check("wlost_one_cycle", bus.wlost, 32'h0);

        // equal spread: lower core index wins everywhere
        put_write(4, 7, 3, 16'h4444);
        put_write(6, 7, 3, 16'h6666);
        tick();
        clear_writes();
        read_all(7);
        tick();
        check("tie_wlost6", bus.wlost[6], 1'b1);
        check("tie_wlost4", bus.wlost[4], 1'b0);
        for (int b = 0; b < C; b++)
            check($sformatf("tie_blk%0d", b), bus.rdata[b*DW +: DW], 32'h4444);

        // broadcast to io port 1
        put_write(2, 241, 4, 16'h00FF);
        tick();
        clear_writes();
        tick();
        check("bc_valid1", bus.io_valid_out[1], 1'b1);
        check("bc_data1", bus.io_data_out[1*DW +: DW], 32'h00FF);
        check("bc_overrun_clear", bus.io_overrun[1], 1'b0);
        check("bc_other_ports", {bus.io_valid_out[15:2], bus.io_valid_out[0]}, 32'h0);
        tick();
        check("bc_hold_data", bus.io_data_out[1*DW +: DW], 32'h00FF);

        // second broadcast with the oversize spread 7 while not ready
        put_write(5, 241, 7, 16'h0123);
        tick();
        clear_writes();
        tick();
        check("ovr_set", bus.io_overrun[1], 1'b1);
        check("ovr_valid", bus.io_valid_out[1], 1'b1);
        check("ovr_data", bus.io_data_out[1*DW +: DW], 32'h0123);
        bus.io_ready_in[1] = 1'b1;
        tick();
        check("ready_clears_valid", bus.io_valid_out[1], 1'b0);
        check("overrun_sticky", bus.io_overrun[1], 1'b1);
        bus.io_ready_in = '0;

        // io input beats a core broadcast to the same cell
        bus.io_active_in[0]       = 1'b1;
        bus.io_data_in[0 +: DW]   = 16'h5A5A;
        put_write(7, 240, 4, 16'h7777);
        tick();
        clear_writes();
        read_all(240);
        tick();
        check("io_in_wlost7", bus.wlost[7], 1'b1);
        for (int b = 0; b < C; b++)
            check($sformatf("io_in_blk%0d", b), bus.rdata[b*DW +: DW], 32'h5A5A);
        check("io_in_no_echo", bus.io_valid_out[0], 1'b0);

        // async reset between stage and commit
        put_write(0, 20, 4, 16'hDEAD);
        tick();
        clear_writes();
        read_all(20);
        #2;
        rst = 1'b1;
        #1;
        check("async_rdata", bus.rdata, 32'h0);
        check("async_overrun", bus.io_overrun, 32'h0);
        check("async_valid", bus.io_valid_out, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        for (int b = 0; b < C; b++)
            check($sformatf("rst_discard_blk%0d", b), bus.rdata[b*DW +: DW], 32'h0);
        check("rst_wlost", bus.wlost, 32'h0);
        bus.raddr[3*AW +: AW] = 8'd5;
        bus.raddr[0*AW +: AW] = 8'd240;
        tick();
        check("rst_mem_cleared5", bus.rdata[3*DW +: DW], 32'h0);
        check("rst_mem_cleared240", bus.rdata[0*DW +: DW], 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
